fifo_drain_arbiter: RTL and testbench
=====================================

FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of source FIFO channels (power of 2, 2..8).
REQ-002 Parameter WIDTH, default 9: source FIFO address width; fill inputs are WIDTH+1 bits.
REQ-003 Parameter DW, default 16: data word width per channel.
REQ-004 Parameter BURST_LOG, default 4: maximal burst length is 2**BURST_LOG words.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  arbitration enable; sampled only in IDLE.
REQ-008 fill  input  NCH*(WIDTH+1)  per-channel FIFO RAM fill level; channel i at bits [i*(WIDTH+1) +: WIDTH+1].
REQ-009 nempty  input  NCH  per-channel FIFO output-register valid.
REQ-010 flush  input  NCH  per-channel request to drain a partial burst.
REQ-011 din  input  NCH*DW  per-channel FIFO output data; channel i at [i*DW +: DW].
REQ-012 dst_ready  input  1  downstream can accept a new burst; sampled only in IDLE.
REQ-013 rd  output  NCH  per-channel FIFO read strobe, at most one bit high.
REQ-014 burst_start  output  1  one-cycle pulse, burst granted.
REQ-015 burst_chn  output  log2(NCH)  granted channel, held from burst_start to burst_done.
REQ-016 burst_len  output  BURST_LOG+1  granted length in words, held with burst_chn.
REQ-017 dout  output  DW  registered data word.
REQ-018 dout_valid  output  1  dout qualifier.
REQ-019 burst_done  output  1  one-cycle pulse after the last word is output.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 States: IDLE, GRANT, READ, DONE; one-hot or binary encoding, implementer's choice.
REQ-022 Channel i is eligible when fill_i >= 2**BURST_LOG, or when flush[i] is high and (fill_i != 0 or nempty[i] is high).
REQ-023 IDLE -> GRANT when en, dst_ready and at least one eligible channel in the same cycle; else stay in IDLE.
REQ-024 Selection is round-robin: the first eligible channel searching upward from last_chn+1 modulo NCH.
REQ-025 On the IDLE->GRANT transition, latch burst_chn and burst_len = min(fill_i + nempty[i], 2**BURST_LOG).
REQ-026 Compute burst_len at BURST_LOG+2 bits internally with no truncation before the min.
REQ-027 GRANT lasts exactly one cycle: burst_start = 1, remaining counter <= burst_len; then -> READ.
REQ-028 READ: rd[burst_chn] = (remaining != 0) && nempty[burst_chn]; all other rd bits are 0.
REQ-029 remaining decrements by 1 on each cycle with a rd strobe.
REQ-030 READ -> DONE in the cycle after remaining reaches 0.
REQ-031 A nempty[burst_chn] low during READ stalls reads without a state change; no timeout.
REQ-032 Data path: on a rd cycle, dout <= din[burst_chn] and dout_valid <= 1; otherwise dout_valid <= 0 and dout holds its value.
REQ-033 Latency is one clock from rd to dout_valid.
REQ-034 DONE lasts one cycle: burst_done = 1, last_chn <= burst_chn; then -> IDLE.
REQ-035 Back-to-back bursts: at least 2 idle cycles (DONE, IDLE) separate the last rd of one burst from the burst_start of the next.
REQ-036 Mid-burst changes to en, flush, dst_ready or fill do not abort or alter the burst in progress.
REQ-037 Total rd strobes per burst equal burst_len exactly, and dout_valid pulses equal burst_len.
REQ-038 burst_len = 0 never occurs; eligibility guarantees at least 1 word.

Reset
REQ-039 rst_n low asynchronously forces IDLE with all outputs 0: rd, burst_start, burst_chn, burst_len, dout, dout_valid, burst_done, busy.
REQ-040 rst_n low also clears remaining = 0 and sets last_chn = NCH-1, so channel 0 has first priority.
REQ-041 Reset asserted mid-burst abandons the burst with no burst_done; source FIFOs are reset separately by the owner.
REQ-042 Reset release is not synchronized internally; the integrating block supplies a release synchronized to clk.

Verification
REQ-043 Scenario: reset; fill0 = 16, nempty0 = 1, en = dst_ready = 1 -> burst_start with chn 0 and len 16, 16 rd[0] strobes, 16 dout_valid, burst_done.
REQ-044 Scenario: fill0 = fill1 = fill2 = 40, all held -> grants in order 0, 1, 2, 0.
REQ-045 Scenario: fill3 = 0, nempty3 = 1, flush3 = 1 -> len 1, a single rd[3], dout = din3 one cycle later.
REQ-046 Scenario: during READ on chn 1 with len 16, nempty1 low for 5 cycles after word 7 -> rd stalls 5 cycles, 16 words total, no other rd bit asserts.
REQ-047 Scenario: dst_ready = 0 with eligible channels -> stays IDLE, busy = 0; dst_ready dropped after burst_start -> burst completes.
REQ-048 Scenario: rst_n low at remaining = 9 -> all outputs 0 immediately; after release the next grant goes to channel 0.

Source files
------------

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst arbiter draining NCH source FIFOs into one stream.
// Grants a burst of up to 2**BURST_LOG words to one channel at a time.
module fifo_drain_arbiter #(
    parameter int NCH       = 4,
    parameter int WIDTH     = 9,
    parameter int DW        = 16,
    parameter int BURST_LOG = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NCH*(WIDTH+1)-1:0]   fill,
    input  logic [NCH-1:0]             nempty,
    input  logic [NCH-1:0]             flush,
    input  logic [NCH*DW-1:0]          din,
    input  logic                       dst_ready,
    output logic [NCH-1:0]             rd,
    output logic                       burst_start,
    output logic [$clog2(NCH)-1:0]     burst_chn,
    output logic [BURST_LOG:0]         burst_len,
    output logic [DW-1:0]              dout,
    output logic                       dout_valid,
    output logic                       burst_done,
    output logic                       busy
);

    localparam int FW   = WIDTH + 1;
    localparam int CW   = $clog2(NCH);
    localparam int MAXB = 1 << BURST_LOG;
    localparam logic [FW:0] MAXW = (FW+1)'(MAXB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_READ,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_last_chn;
    logic [CW-1:0]       r_burst_chn;
    logic [BURST_LOG:0]  r_burst_len;
    logic [BURST_LOG:0]  r_remaining;
    logic [DW-1:0]       r_dout;
    logic                r_dout_valid;

    logic [NCH-1:0]      w_elig;
    logic [FW-1:0]       w_fill_i;
    logic [CW-1:0]       w_idx;
    logic [CW-1:0]       w_sel;
    logic                w_found;
    logic [FW:0]         w_sum;
    logic [BURST_LOG:0]  w_len;
    logic                w_rd_en;

    // Per-channel eligibility: full burst available, or flush with any data
    always_comb begin
        w_elig   = '0;
        w_fill_i = '0;
        for (int i = 0; i < NCH; i++) begin
            w_fill_i  = fill[i*FW +: FW];
            w_elig[i] = ({1'b0, w_fill_i} >= MAXW) ||
                        (flush[i] && ((w_fill_i != '0) || nempty[i]));
        end
    end

    // Round-robin pick starting after the last served channel
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_idx = r_last_chn + CW'(k);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Burst length: words in RAM plus output register, capped at max burst
    always_comb begin
        w_sum = {1'b0, fill[int'(w_sel)*FW +: FW]} + (FW+1)'(nempty[w_sel]);
        w_len = (w_sum > MAXW) ? (BURST_LOG+1)'(MAXB) : w_sum[BURST_LOG:0];
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (en && dst_ready && w_found) w_next = S_GRANT;
            S_GRANT: w_next = S_READ;
            S_READ:  if (r_remaining == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Read strobe only toward the granted channel
    always_comb begin
        w_rd_en = (r_state == S_READ) && (r_remaining != '0) &&
                  nempty[r_burst_chn];
        rd = '0;
        rd[r_burst_chn] = w_rd_en;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Grant bookkeeping: channel, length, words remaining, priority pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_chn <= '0;
            r_burst_len <= '0;
            r_remaining <= '0;
            r_last_chn  <= CW'(NCH-1);
        end else begin
            if (r_state == S_IDLE && w_next == S_GRANT) begin
                r_burst_chn <= w_sel;
                r_burst_len <= w_len;
            end
            if (r_state == S_GRANT) r_remaining <= r_burst_len;
            else if (w_rd_en)       r_remaining <= r_remaining - 1'b1;
            if (r_state == S_DONE) r_last_chn <= r_burst_chn;
        end
    end

    // Output data register, one clock behind the read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_en;
            if (w_rd_en) r_dout <= din[int'(r_burst_chn)*DW +: DW];
        end
    end

    assign burst_start = (r_state == S_GRANT);
    assign burst_done  = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign burst_chn   = r_burst_chn;
    assign burst_len   = r_burst_len;
    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: vector table plus
// round-robin, stall and mid-burst reset sequences.
module tb_fifo_drain_arbiter;

    localparam int NCH = 4;
    localparam int WIDTH = 9;
    localparam int DW = 16;
    localparam int BL = 4;
    localparam int FW = WIDTH + 1;

    logic                   clk = 0;
    logic                   rst_n = 0;
    logic                   en = 0;
    logic [NCH*FW-1:0]      fill = '0;
    logic [NCH-1:0]         nempty = '0;
    logic [NCH-1:0]         flush = '0;
    logic [NCH*DW-1:0]      din = '0;
    logic                   dst_ready = 0;
    logic [NCH-1:0]         rd;
    logic                   burst_start;
    logic [1:0]             burst_chn;
    logic [BL:0]            burst_len;
    logic [DW-1:0]          dout;
    logic                   dout_valid;
    logic                   burst_done;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    fifo_drain_arbiter #(
        .NCH(NCH), .WIDTH(WIDTH), .DW(DW), .BURST_LOG(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fill(fill),
        .nempty(nempty), .flush(flush), .din(din),
        .dst_ready(dst_ready), .rd(rd), .burst_start(burst_start),
        .burst_chn(burst_chn), .burst_len(burst_len), .dout(dout),
        .dout_valid(dout_valid), .burst_done(burst_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [NCH*FW-1:0] fill;
        logic [NCH-1:0]    nempty;
        logic [NCH-1:0]    flush;
        logic              en;
        logic              dst;
        logic              exp_go;
        int                exp_chn;
        int                exp_len;
        string             name;
    } vec_t;

    vec_t tv[13];

    function automatic logic [NCH*FW-1:0] pack(int a, int b, int c, int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_din;
        for (int i = 0; i < NCH; i++) din[i*DW +: DW] = 16'($urandom);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({rd, burst_start, burst_chn, burst_len,
                    dout, dout_valid, burst_done, busy});
    endfunction

    task automatic do_reset(input string nm);
        rst_n = 0;
        en = 0; fill = '0; nempty = '0; flush = '0; dst_ready = 0;
        cyc;
        cyc;
        chk({nm, "_rst_outs"}, all_outs(), 64'd0);
        rst_n = 1;
    endtask

    task automatic wait_start(input int bound, output bit got,
                              output int waited);
        got = 0;
        waited = 0;
        for (int c = 0; c < bound; c++) begin
            cyc;
            waited++;
            if (burst_start) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic run_burst(input int chn, input int len,
                             input int stall_after, input int stall_cyc,
                             input bit mid, input string nm);
        int rdc = 0;
        int vc = 0;
        int bad = 0;
        int stray = 0;
        int iters = 0;
        int stalled = 0;
        bit prev = 0;
        bit done = 0;
        logic [DW-1:0] expd = '0;
        logic [NCH-1:0] mask;
        if (mid) begin
            en = 0; dst_ready = 0; flush = '0; fill = '0;
        end
        nempty = '1;
        rand_din;
        mask = ~(4'b0001 << chn);
        for (int c = 0; c < 200; c++) begin
            cyc;
            if (dout_valid) vc++;
            if (dout_valid !== prev) bad++;
            else if (prev && dout !== expd) bad++;
            if (burst_done) begin
                done = 1;
                break;
            end
            iters++;
            nempty = '1;
            if (rdc == stall_after && stalled < stall_cyc) begin
                nempty[chn] = 1'b0;
                stalled++;
            end
            rand_din;
            #1;
            prev = rd[chn];
            if (prev) begin
                rdc++;
                expd = din[chn*DW +: DW];
            end
            if ((rd & mask) != '0) stray++;
        end
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_rd_count"}, 64'(rdc), 64'(len));
        chk({nm, "_valid_count"}, 64'(vc), 64'(len));
        chk({nm, "_data_bad"}, 64'(bad), 64'd0);
        chk({nm, "_stray_rd"}, 64'(stray), 64'd0);
        chk({nm, "_read_cycles"}, 64'(iters), 64'(len + stall_cyc + 1));
    endtask

    initial begin
        bit got;
        int waited;
        int order[4];

        tv[0]  = '{pack(16,0,0,0),     4'b0001, 4'b0000, 1, 1, 1, 0, 16, "full16"};
        tv[1]  = '{pack(0,0,0,0),      4'b1000, 4'b1000, 1, 1, 1, 3, 1,  "flush1"};
        tv[2]  = '{pack(0,0,5,0),      4'b0100, 4'b0100, 1, 1, 1, 2, 6,  "flush6"};
        tv[3]  = '{pack(0,15,0,0),     4'b0010, 4'b0000, 1, 1, 0, 0, 0,  "below"};
        tv[4]  = '{pack(0,15,0,0),     4'b0010, 4'b0010, 1, 1, 1, 1, 16, "flush16"};
        tv[5]  = '{pack(0,3,0,0),      4'b0000, 4'b0010, 1, 1, 1, 1, 3,  "flush3"};
        tv[6]  = '{pack(40,40,40,40),  4'b1111, 4'b0000, 1, 1, 1, 0, 16, "all40"};
        tv[7]  = '{pack(40,40,40,40),  4'b1111, 4'b0000, 0, 1, 0, 0, 0,  "en0"};
        tv[8]  = '{pack(40,40,40,40),  4'b1111, 4'b0000, 1, 0, 0, 0, 0,  "dst0"};
        tv[9]  = '{pack(0,0,0,0),      4'b0000, 4'b0100, 1, 1, 0, 0, 0,  "flushempty"};
        tv[10] = '{pack(0,20,0,16),    4'b0000, 4'b0000, 1, 1, 1, 1, 16, "prio"};
        tv[11] = '{pack(0,0,1023,0),   4'b0100, 4'b0000, 1, 1, 1, 2, 16, "bigfill"};
        tv[12] = '{pack(0,0,0,16),     4'b0000, 4'b0000, 1, 1, 1, 3, 16, "exact16"};

        for (int i = 0; i < 13; i++) begin
            do_reset(tv[i].name);
            fill = tv[i].fill;
            nempty = tv[i].nempty;
            flush = tv[i].flush;
            en = tv[i].en;
            dst_ready = tv[i].dst;
            wait_start(4, got, waited);
            chk({tv[i].name, "_go"}, 64'(got), 64'(tv[i].exp_go));
            if (tv[i].exp_go && got) begin
                chk({tv[i].name, "_chn"}, 64'(burst_chn), 64'(tv[i].exp_chn));
                chk({tv[i].name, "_len"}, 64'(burst_len), 64'(tv[i].exp_len));
                run_burst(tv[i].exp_chn, tv[i].exp_len, -1, 0,
                          1'(i % 2), tv[i].name);
            end else begin
                chk({tv[i].name, "_idle_busy"}, 64'(busy), 64'd0);
                chk({tv[i].name, "_idle_rd"}, 64'(rd), 64'd0);
            end
        end

        do_reset("rr");
        fill = pack(40, 40, 40, 0);
        nempty = 4'b0111;
        en = 1;
        dst_ready = 1;
        order = '{0, 1, 2, 0};
        for (int g = 0; g < 4; g++) begin
            wait_start(6, got, waited);
            chk("rr_go", 64'(got), 64'd1);
            chk("rr_chn", 64'(burst_chn), 64'(order[g]));
            if (g > 0) chk("rr_gap_ge2", 64'(waited >= 2), 64'd1);
            if (got) run_burst(order[g], 16, -1, 0, 0, "rr");
        end

        do_reset("stall");
        fill = pack(0, 20, 0, 0);
        nempty = 4'b0010;
        en = 1;
        dst_ready = 1;
        wait_start(4, got, waited);
        chk("stall_go", 64'(got), 64'd1);
        chk("stall_chn", 64'(burst_chn), 64'd1);
        chk("stall_len", 64'(burst_len), 64'd16);
        if (got) run_burst(1, 16, 7, 5, 0, "stall");

        do_reset("mrst");
        fill = pack(40, 40, 40, 0);
        nempty = 4'b0111;
        en = 1;
        dst_ready = 1;
        wait_start(4, got, waited);
        chk("mrst_first_chn", 64'(burst_chn), 64'd0);
        if (got) run_burst(0, 16, -1, 0, 0, "mrst_first");
        wait_start(6, got, waited);
        chk("mrst_second_chn", 64'(burst_chn), 64'd1);
        nempty = '1;
        repeat (8) cyc;
        chk("mrst_pre_busy", 64'(busy), 64'd1);
        chk("mrst_pre_valid", 64'(dout_valid), 64'd1);
        rst_n = 0;
        #1;
        chk("mrst_async_outs", all_outs(), 64'd0);
        cyc;
        chk("mrst_no_done", 64'(burst_done), 64'd0);
        rst_n = 1;
        wait_start(4, got, waited);
        chk("mrst_after_go", 64'(got), 64'd1);
        chk("mrst_after_chn", 64'(burst_chn), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
